// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: next-PC sequencer covering boot delay, +4, branch, trap entry, mret, stall and halt.
// Outputs are combinational from state and inputs so the PC register latches them on the same edge.
module pc_next_ctrl #(
   parameter logic [63:0] RESET_VEC   = 64'h8000_0000,
   parameter int          BOOT_CYCLES = 2,
   parameter int          TRAPCNT_W   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [63:0]          pc_i,
   input  logic                 stall_i,
   input  logic                 branch_valid_i,
   input  logic [63:0]          branch_target_i,
   input  logic                 trap_valid_i,
   input  logic [63:0]          mtvec_i,
   input  logic                 mret_i,
   input  logic                 halt_i,
   output logic [63:0]          npc_o,
   output logic                 pc_we_o,
   output logic                 redirect_o,
   output logic [63:0]          mepc_o,
   output logic [1:0]           state_o,
   output logic [TRAPCNT_W-1:0] trap_cnt_o
);
   typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, TRAP = 2'b10, HALT = 2'b11} state_e;
   state_e               state_q, state_d;
   logic [31:0]          boot_cnt_q, boot_cnt_d;
   logic [63:0]          mepc_q, mepc_d;
   logic [TRAPCNT_W-1:0] trap_cnt_q, trap_cnt_d;
   logic                 take_trap;
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      mepc_d     = mepc_q;
      trap_cnt_d = trap_cnt_q;
      npc_o      = pc_i;
      pc_we_o    = 1'b0;
      redirect_o = 1'b0;
      take_trap  = 1'b0;
      case (state_q)
         BOOT: begin
            npc_o      = RESET_VEC;
            boot_cnt_d = boot_cnt_q + 32'd1;
            if (boot_cnt_q == 32'(BOOT_CYCLES - 1)) state_d = RUN;
         end
         RUN: begin
            if (halt_i) state_d = HALT;
            else if (trap_valid_i) take_trap = 1'b1;
            else if (mret_i) begin
               npc_o      = mepc_q;
               pc_we_o    = 1'b1;
               redirect_o = 1'b1;
            end else if (branch_valid_i) begin
               // A misaligned target raises an exception instead of redirecting
               if (branch_target_i[1:0] != 2'b00) take_trap = 1'b1;
               else begin
                  npc_o      = branch_target_i;
                  pc_we_o    = 1'b1;
                  redirect_o = 1'b1;
               end
            end else if (!stall_i) begin
               npc_o   = pc_i + 64'd4;
               pc_we_o = 1'b1;
            end
         end
         TRAP: begin
            npc_o      = {mtvec_i[63:2], 2'b00};
            pc_we_o    = 1'b1;
            redirect_o = 1'b1;
            state_d    = RUN;
         end
         HALT: ;
      endcase
      if (take_trap) begin
         mepc_d     = pc_i;
         trap_cnt_d = &trap_cnt_q ? trap_cnt_q : trap_cnt_q + TRAPCNT_W'(1);
         state_d    = TRAP;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= BOOT;
         boot_cnt_q <= '0;
         mepc_q     <= '0;
         trap_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         mepc_q     <= mepc_d;
         trap_cnt_q <= trap_cnt_d;
      end
   end
   assign mepc_o     = mepc_q;
   assign state_o    = state_q;
   assign trap_cnt_o = trap_cnt_q;
endmodule
